// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS32 control FSM
// Sequences PC update, IR latch, register-file write and the shared memory port
// for one instruction at a time. Optional macro: ILLEGAL_TRAP_EN (illegal opcode
// traps to FAULT when defined, otherwise it is treated as a NOP).
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   start_i                       leave IDLE and begin fetching
//   instr_i[31:0]                 instruction register contents
//   alu_zero_i                    ALU zero flag for beq
//   mem_ready_i                   memory completes the current request
//   mem_req_o, mem_we_o           memory request / store
//   ir_write_o, pc_write_o        IR latch / PC+4 strobes
//   is_jump_o                     PC <= jump target strobe
//   reg_write_o, reg_dst_o        register write enable / rd-vs-rt select
//   mem_to_reg_o                  write-back from memory
//   alu_src_o, alu_op_o[1:0]      ALU operand / operation selects
//   state_o[2:0], busy_o, fault_o debug state, busy, sticky fault
module mc_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] instr_i,
  input  logic        alu_zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        is_jump_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_op_o,
  output logic [2:0]  state_o,
  output logic        busy_o,
  output logic        fault_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [2:0]      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] cnt_inc;
  logic [5:0]      opcode;
  logic            op_legal;
  logic            unused_instr;

  assign opcode       = instr_i[31:26];
  assign unused_instr = ^instr_i[25:0];
  assign cnt_inc      = cnt_q + TO_W'(1);

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    is_jump_o    = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = 2'b00;
    fault_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (cnt_inc == TO_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_FAULT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op_o = 2'b10;
            state_d  = S_WB;
          end
          OP_ADDI: begin
            alu_src_o = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_o = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op_o  = 2'b01;
            is_jump_o = alu_zero_i;
            state_d   = S_FETCH;
          end
          default: begin
            // only j reaches here: DECODE filters illegal opcodes
            is_jump_o = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (opcode == OP_SW);
        if (mem_ready_i) begin
          state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
        end else if (cnt_inc == TO_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (opcode == OP_R);
        mem_to_reg_o = (opcode == OP_LW);
        state_d      = S_FETCH;
      end
      S_FAULT: begin
        fault_o = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    // any state change restarts the wait counter, so FETCH/MEM always enter at 0
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign busy_o  = (state_q != S_IDLE) && (state_q != S_FAULT);

endmodule
